// File: rtl/sa_os_array_ctrl.sv
// Output-stationary ROWS x COLS systolic MAC array with skewed operand entry and job sequencing FSM.
// Latency: k_len + ROWS + COLS - 1 edges from start to first result row when no input bubbles occur.
// Backpressure: in_ready only in LOAD (gaps become bubbles); DRAIN holds out_row/out_idx until out_ready.
//
// Ports: CLK/RST (async active-high); start/k_len/signed_mode job setup; in_valid/in_ready/a_in/b_in
// operand beats (one K-step per beat); out_valid/out_ready/out_row/out_idx row-by-row result drain;
// busy (not IDLE) and done (one-cycle pulse after the last row is taken).
module sa_os_array_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int WIDTH = 16,
    parameter int ACC_W = 40,
    parameter int KW    = 8,
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    input  logic                   signed_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*ROWS-1:0]  a_in,
    input  logic [WIDTH*COLS-1:0]  b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W*COLS-1:0]  out_row,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int FW = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_len_q, k_len_d;
    logic [KW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              signed_q, signed_d;
    logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              in_hs, out_hs, acc_clr, acc_run;

    // Input skew: lane r of A (lane c of B) is read out of stage r (stage c),
    // so a beat lands in PE(r,c) exactly r+c edges after PE(0,0).
    logic [WIDTH-1:0]  a_sk_q [ROWS][ROWS];
    logic [WIDTH-1:0]  a_sk_d [ROWS][ROWS];
    logic              va_sk_q[ROWS][ROWS];
    logic              va_sk_d[ROWS][ROWS];
    logic [WIDTH-1:0]  b_sk_q [COLS][COLS];
    logic [WIDTH-1:0]  b_sk_d [COLS][COLS];
    logic              vb_sk_q[COLS][COLS];
    logic              vb_sk_d[COLS][COLS];

    // Per-PE forwarding registers (A moves right, B moves down) and accumulators.
    logic [WIDTH-1:0]  a_h_q [ROWS][COLS];
    logic [WIDTH-1:0]  a_h_d [ROWS][COLS];
    logic              va_h_q[ROWS][COLS];
    logic              va_h_d[ROWS][COLS];
    logic [WIDTH-1:0]  b_v_q [ROWS][COLS];
    logic [WIDTH-1:0]  b_v_d [ROWS][COLS];
    logic              vb_v_q[ROWS][COLS];
    logic              vb_v_d[ROWS][COLS];
    logic [ACC_W-1:0]  acc_q [ROWS][COLS];
    logic [ACC_W-1:0]  acc_d [ROWS][COLS];

    // Operands seen by each PE this cycle.
    logic [WIDTH-1:0]  pe_a [ROWS][COLS];
    logic [WIDTH-1:0]  pe_b [ROWS][COLS];
    logic              pe_va[ROWS][COLS];
    logic              pe_vb[ROWS][COLS];

    function automatic logic [ACC_W-1:0] mac_term(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
        logic [2*WIDTH-1:0] p;
        if (sgn) begin
            p = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
            return ACC_W'($signed(p));
        end else begin
            p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
            return ACC_W'(p);
        end
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            signed_q    <= 1'b0;
            flush_cnt_q <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            signed_q    <= signed_d;
            flush_cnt_q <= flush_cnt_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        signed_d    = signed_q;
        flush_cnt_d = flush_cnt_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_len_d     = k_len;
                    signed_d    = signed_mode;
                    beat_cnt_d  = '0;
                    flush_cnt_d = '0;
                    idx_d       = '0;
                    state_d     = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (in_hs) begin
                    if (beat_cnt_q == k_len_q - KW'(1)) begin
                        beat_cnt_d = '0;
                        state_d    = FLUSH;
                    end else begin
                        beat_cnt_d = beat_cnt_q + KW'(1);
                    end
                end
            end
            FLUSH: begin
                // The last beat needs ROWS+COLS-1 more edges to reach PE(ROWS-1,COLS-1).
                if (flush_cnt_q == FW'(ROWS + COLS - 2)) begin
                    flush_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (idx_q == IDX_W'(ROWS - 1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == DRAIN);
        busy      = (state_q != IDLE);
        done      = done_q;
        out_idx   = idx_q;
        in_hs     = in_valid & in_ready;
        out_hs    = out_valid & out_ready;
        acc_clr   = (state_q == IDLE) & start;
        acc_run   = (state_q == LOAD) | (state_q == FLUSH);
        for (int c = 0; c < COLS; c++) begin
            out_row[c*ACC_W +: ACC_W] = acc_q[idx_q][c];
        end
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            a_sk_d[r][0]  = a_in[r*WIDTH +: WIDTH];
            va_sk_d[r][0] = in_hs;
            for (int k = 1; k < ROWS; k++) begin
                a_sk_d[r][k]  = a_sk_q[r][k-1];
                va_sk_d[r][k] = va_sk_q[r][k-1];
            end
        end
        for (int c = 0; c < COLS; c++) begin
            b_sk_d[c][0]  = b_in[c*WIDTH +: WIDTH];
            vb_sk_d[c][0] = in_hs;
            for (int k = 1; k < COLS; k++) begin
                b_sk_d[c][k]  = b_sk_q[c][k-1];
                vb_sk_d[c][k] = vb_sk_q[c][k-1];
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pe_a[r][c]  = (c == 0) ? a_sk_q[r][r]  : a_h_q[r][(c > 0) ? c - 1 : 0];
                pe_va[r][c] = (c == 0) ? va_sk_q[r][r] : va_h_q[r][(c > 0) ? c - 1 : 0];
                pe_b[r][c]  = (r == 0) ? b_sk_q[c][c]  : b_v_q[(r > 0) ? r - 1 : 0][c];
                pe_vb[r][c] = (r == 0) ? vb_sk_q[c][c] : vb_v_q[(r > 0) ? r - 1 : 0][c];
                a_h_d[r][c]  = pe_a[r][c];
                va_h_d[r][c] = pe_va[r][c];
                b_v_d[r][c]  = pe_b[r][c];
                vb_v_d[r][c] = pe_vb[r][c];
                acc_d[r][c]  = acc_q[r][c];
                if (acc_clr) begin
                    acc_d[r][c] = '0;
                end else if (acc_run && pe_va[r][c] && pe_vb[r][c]) begin
                    acc_d[r][c] = acc_q[r][c] + mac_term(pe_a[r][c], pe_b[r][c], signed_q);
                end
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < ROWS; k++) begin
                    a_sk_q[r][k]  <= '0;
                    va_sk_q[r][k] <= 1'b0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                for (int k = 0; k < COLS; k++) begin
                    b_sk_q[c][k]  <= '0;
                    vb_sk_q[c][k] <= 1'b0;
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_h_q[r][c]  <= '0;
                    va_h_q[r][c] <= 1'b0;
                    b_v_q[r][c]  <= '0;
                    vb_v_q[r][c] <= 1'b0;
                    acc_q[r][c]  <= '0;
                end
            end
        end else begin
            a_sk_q  <= a_sk_d;
            va_sk_q <= va_sk_d;
            b_sk_q  <= b_sk_d;
            vb_sk_q <= vb_sk_d;
            a_h_q   <= a_h_d;
            va_h_q  <= va_h_d;
            b_v_q   <= b_v_d;
            vb_v_q  <= vb_v_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_sa_os_array_ctrl.sv
// Directed bench for sa_os_array_ctrl: default 4x4/16b/40b instance plus a 32-bit accumulator instance.
// Expected results are hand-computed per scenario; each test task checks its own outcome.
// Outputs are sampled 1 time unit after the rising clock edge; inputs are driven at the same point.
module tb_sa_os_array_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic [7:0]   k_len;
    logic         signed_mode;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  a_in;
    logic [63:0]  b_in;
    logic         out_valid;
    logic         out_ready;
    logic [159:0] out_row;
    logic [1:0]   out_idx;
    logic         busy;
    logic         done;

    logic         w_start;
    logic [7:0]   w_k_len;
    logic         w_signed;
    logic         w_in_valid;
    logic         w_in_ready;
    logic [63:0]  w_a_in;
    logic [63:0]  w_b_in;
    logic         w_out_valid;
    logic         w_out_ready;
    logic [127:0] w_out_row;
    logic [1:0]   w_out_idx;
    logic         w_busy;
    logic         w_done;

    int checks = 0;
    int errors = 0;

    // Job recorder state
    logic [63:0]  beat_a [8];
    logic [63:0]  beat_b [8];
    logic [15:0]  vpat;
    logic         inj_start;
    int           stall_row;
    int           stall_n;
    logic [159:0] res_row [8];
    logic [1:0]   res_idx [8];
    int           nrows, lat, done_cnt, rows_at_done, stall_cycles;
    logic         stall_bad, timeout;

    sa_os_array_ctrl u_dut (
        .CLK(clk), .RST(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    sa_os_array_ctrl #(.ACC_W(32)) u_dut32 (
        .CLK(clk), .RST(rst), .start(w_start), .k_len(w_k_len), .signed_mode(w_signed),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .a_in(w_a_in), .b_in(w_b_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_row(w_out_row), .out_idx(w_out_idx),
        .busy(w_busy), .done(w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one job on the main instance and records what came out; no checking here.
    task automatic run_job(input logic [7:0] k, input logic sgn);
        int bi, step, cyc, post, stall_left;
        logic hs_in, held_v, seen_done;
        logic [159:0] held_row;
        logic [1:0] held_idx;
        bi = 0; step = 0; post = 0; stall_left = stall_n;
        held_v = 1'b0; seen_done = 1'b0; held_row = '0; held_idx = '0;
        nrows = 0; lat = -1; done_cnt = 0; rows_at_done = -1; stall_cycles = 0;
        stall_bad = 1'b0; timeout = 1'b0;
        for (int i = 0; i < 8; i++) begin
            res_row[i] = '0;
            res_idx[i] = '0;
        end
        start = 1'b1; k_len = k; signed_mode = sgn; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (post < 3 && cyc < 300) begin
            if (out_valid && lat < 0) lat = cyc;
            if (done) begin
                done_cnt++;
                if (!seen_done) rows_at_done = nrows;
                seen_done = 1'b1;
            end
            if (seen_done) post++;
            start = 1'b0;
            in_valid = 1'b0;
            if (in_ready) begin
                if (inj_start && step == 1) begin
                    start = 1'b1;
                    k_len = 8'd0;
                end
                in_valid = (bi < int'(k)) && ((step > 15) || vpat[step]);
                if (bi < 8) begin
                    a_in = beat_a[bi];
                    b_in = beat_b[bi];
                end
                step++;
            end
            out_ready = 1'b1;
            if (out_valid && int'(out_idx) == stall_row) begin
                if (held_v && (out_row !== held_row || out_idx !== held_idx)) stall_bad = 1'b1;
                held_v = 1'b1; held_row = out_row; held_idx = out_idx;
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    stall_cycles++;
                end
            end
            if (out_valid && out_ready) begin
                if (nrows < 8) begin
                    res_row[nrows] = out_row;
                    res_idx[nrows] = out_idx;
                end
                nrows++;
            end
            hs_in = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs_in) bi++;
        end
        if (cyc >= 300) timeout = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic set_basic_beats();
        for (int i = 0; i < 8; i++) begin
            beat_a[i] = 64'h0001_0001_0001_0001;
            beat_b[i] = 64'h0002_0002_0002_0002;
        end
        vpat = 16'hFFFF; inj_start = 1'b0; stall_row = -1; stall_n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (out_row !== 160'd0)  begin errors++; $display("FAIL reset_out_row: got %h want 0", out_row); end
        checks++; if (out_idx !== 2'd0)    begin errors++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        set_basic_beats();
        run_job(8'd3, 1'b0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: job did not complete"); end
        checks++; if (lat !== 11)       begin errors++; $display("FAIL basic_latency: got %0d want 11", lat); end
        checks++; if (nrows !== 4)      begin errors++; $display("FAIL basic_rows: got %0d want 4", nrows); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (res_idx[i] !== 2'(i)) begin errors++; $display("FAIL basic_idx%0d: got %0d want %0d", i, res_idx[i], i); end
            checks++;
            if (res_row[i] !== {4{40'd6}}) begin errors++; $display("FAIL basic_row%0d: got %h want %h", i, res_row[i], {4{40'd6}}); end
        end
        checks++; if (done_cnt !== 1)     begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++; if (rows_at_done !== 4) begin errors++; $display("FAIL basic_done_after_rows: got %0d want 4", rows_at_done); end
    endtask

    task automatic test_signed();
        logic [159:0] exp;
        set_basic_beats();
        beat_a[0] = 64'h0000_0000_0000_FFFD;
        beat_a[1] = 64'h0000_0000_0000_FFFF;
        beat_b[0] = 64'h0000_0000_0000_0005;
        beat_b[1] = 64'h0000_0000_0000_0004;
        run_job(8'd2, 1'b1);
        checks++; if (lat !== 10)  begin errors++; $display("FAIL signed_latency: got %0d want 10", lat); end
        checks++; if (nrows !== 4) begin errors++; $display("FAIL signed_rows: got %0d want 4", nrows); end
        for (int i = 0; i < 4; i++) begin
            exp = (i == 0) ? {120'd0, 40'hFF_FFFF_FFED} : 160'd0;
            checks++;
            if (res_row[i] !== exp) begin errors++; $display("FAIL signed_row%0d: got %h want %h", i, res_row[i], exp); end
        end
    endtask

    task automatic test_bubbles();
        set_basic_beats();
        vpat = 16'h0015;
        run_job(8'd3, 1'b0);
        checks++; if (lat !== 13)  begin errors++; $display("FAIL bubble_latency: got %0d want 13", lat); end
        checks++; if (nrows !== 4) begin errors++; $display("FAIL bubble_rows: got %0d want 4", nrows); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (res_row[i] !== {4{40'd6}}) begin errors++; $display("FAIL bubble_row%0d: got %h want %h", i, res_row[i], {4{40'd6}}); end
        end
    endtask

    task automatic test_stall();
        logic [159:0] exp;
        set_basic_beats();
        for (int i = 0; i < 8; i++) begin
            beat_a[i] = 64'h0004_0003_0002_0001;
            beat_b[i] = 64'h0004_0003_0002_0001;
        end
        stall_row = 1; stall_n = 3;
        run_job(8'd3, 1'b0);
        checks++; if (lat !== 11)          begin errors++; $display("FAIL stall_latency: got %0d want 11", lat); end
        checks++; if (nrows !== 4)         begin errors++; $display("FAIL stall_rows: got %0d want 4", nrows); end
        checks++; if (stall_cycles !== 3)  begin errors++; $display("FAIL stall_cycles: got %0d want 3", stall_cycles); end
        checks++; if (stall_bad !== 1'b0)  begin errors++; $display("FAIL stall_hold: row or idx changed while stalled"); end
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) exp[c*40 +: 40] = 40'(3 * (i + 1) * (c + 1));
            checks++;
            if (res_idx[i] !== 2'(i)) begin errors++; $display("FAIL stall_idx%0d: got %0d want %0d", i, res_idx[i], i); end
            checks++;
            if (res_row[i] !== exp) begin errors++; $display("FAIL stall_row%0d: got %h want %h", i, res_row[i], exp); end
        end
        checks++; if (done_cnt !== 1)     begin errors++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
        checks++; if (rows_at_done !== 4) begin errors++; $display("FAIL stall_done_after_rows: got %0d want 4", rows_at_done); end
    endtask

    task automatic test_zero_len();
        set_basic_beats();
        run_job(8'd0, 1'b0);
        checks++; if (lat !== 1)       begin errors++; $display("FAIL zero_latency: got %0d want 1", lat); end
        checks++; if (nrows !== 4)     begin errors++; $display("FAIL zero_rows: got %0d want 4", nrows); end
        checks++; if (done_cnt !== 1)  begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (res_row[i] !== 160'd0) begin errors++; $display("FAIL zero_row%0d: got %h want 0", i, res_row[i]); end
        end
    endtask

    task automatic test_start_in_load();
        set_basic_beats();
        inj_start = 1'b1;
        run_job(8'd3, 1'b0);
        checks++; if (lat !== 11)  begin errors++; $display("FAIL restart_latency: got %0d want 11", lat); end
        checks++; if (nrows !== 4) begin errors++; $display("FAIL restart_rows: got %0d want 4", nrows); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (res_row[i] !== {4{40'd6}}) begin errors++; $display("FAIL restart_row%0d: got %h want %h", i, res_row[i], {4{40'd6}}); end
        end
    endtask

    task automatic test_wrap();
        int rows, cyc;
        logic [127:0] exp;
        exp = {4{32'hFFFC_0002}};
        w_start = 1'b1; w_k_len = 8'd2; w_signed = 1'b0; w_out_ready = 1'b1; w_in_valid = 1'b0;
        w_a_in = 64'hFFFF_FFFF_FFFF_FFFF;
        w_b_in = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        w_start = 1'b0; w_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        rows = 0; cyc = 0;
        while (rows < 4 && cyc < 60) begin
            if (w_out_valid) begin
                checks++;
                if (w_out_idx !== 2'(rows)) begin errors++; $display("FAIL wrap_idx%0d: got %0d want %0d", rows, w_out_idx, rows); end
                checks++;
                if (w_out_row !== exp) begin errors++; $display("FAIL wrap_row%0d: got %h want %h", rows, w_out_row, exp); end
                rows++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (rows !== 4) begin errors++; $display("FAIL wrap_rows: got %0d want 4", rows); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        set_basic_beats();
        start = 1'b1; k_len = 8'd3; signed_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; a_in = beat_a[0]; b_in = beat_b[0];
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_flush: busy=%b in_ready=%b want 1/0", busy, in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_row !== 160'd0) begin errors++; $display("FAIL midrst_out_row: got %h want 0", out_row); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy=%b out_valid=%b want 0/0", busy, out_valid); end
        run_job(8'd3, 1'b0);
        checks++; if (lat !== 11)  begin errors++; $display("FAIL midrst_next_latency: got %0d want 11", lat); end
        checks++; if (nrows !== 4) begin errors++; $display("FAIL midrst_next_rows: got %0d want 4", nrows); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (res_row[i] !== {4{40'd6}}) begin errors++; $display("FAIL midrst_next_row%0d: got %h want %h", i, res_row[i], {4{40'd6}}); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; in_valid = 1'b0;
        a_in = '0; b_in = '0; out_ready = 1'b1;
        w_start = 1'b0; w_k_len = '0; w_signed = 1'b0; w_in_valid = 1'b0;
        w_a_in = '0; w_b_in = '0; w_out_ready = 1'b1;
        test_reset();
        test_basic();
        test_signed();
        test_bubbles();
        test_stall();
        test_zero_len();
        test_start_in_load();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
